pkt_proc_enq_arb: RTL and testbench

PKT_PROC_ENQ_ARB -- requirements
Module: pkt_proc_enq_arb

---
 rtl/pkt_proc_enq_arb.sv | 142 ++++++++++++++
 tb/tb_pkt_proc_enq_arb.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_proc_enq_arb.sv
// Two-source packet arbiter feeding the packet-processor FIFO: round-robin grant per packet, registered enqueue path.
// Optional per-source packet counters are built when PKT_PROC_ENQ_ARB_STATS_EN is defined.
module pkt_proc_enq_arb (
    input  logic        pck_proc_int_mem_fsm_clk,
    input  logic        pck_proc_int_mem_fsm_sw_rst,
    input  logic [1:0]  src_valid,
    input  logic [1:0]  src_sop,
    input  logic [1:0]  src_eop,
    input  logic [63:0] src_data,
    input  logic [23:0] src_len,
    output logic [1:0]  src_ready,
    input  logic        pck_proc_full,
    input  logic        pck_proc_almost_full,
    output logic        enq_req,
    output logic        in_sop,
    output logic        in_eop,
    output logic        pck_len_valid,
    output logic [31:0] wr_data_i,
    output logic [11:0] pck_len_i,
    output logic        grant_id,
    output logic        busy,
    output logic        protocol_err
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
    ,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1
`endif
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q, state_d;
    logic        rr_prio;     // source that wins the next tie
    logic        first_word;  // next accepted word is the packet's granted sop word
    logic [1:0]  eligible;
    logic [1:0]  stray;
    logic        grant;
    logic        grant_src;
    logic        sel_valid, sel_sop, sel_eop;
    logic [31:0] sel_data;
    logic [11:0] sel_len;
    logic        accept;

    wire clk = pck_proc_int_mem_fsm_clk;
    wire rst = pck_proc_int_mem_fsm_sw_rst;

    assign eligible  = src_valid & src_sop;
    assign stray     = src_valid & ~src_sop;
    assign sel_valid = grant_id ? src_valid[1]     : src_valid[0];
    assign sel_sop   = grant_id ? src_sop[1]       : src_sop[0];
    assign sel_eop   = grant_id ? src_eop[1]       : src_eop[0];
    assign sel_data  = grant_id ? src_data[63:32]  : src_data[31:0];
    assign sel_len   = grant_id ? src_len[23:12]   : src_len[11:0];
    assign accept    = (state_q == XFER) && sel_valid && !pck_proc_full;

    // The sop word is only observed in IDLE; it is consumed in XFER after the grant.
    assign grant     = (state_q == IDLE) && !pck_proc_almost_full && (|eligible);
    assign grant_src = (&eligible) ? rr_prio : eligible[1];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: defaults first in every always_comb so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant)             state_d = XFER;
            XFER: if (accept && sel_eop) state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_comb begin
        src_ready = 2'b00;
        busy      = (state_q == XFER);
        if (!rst) begin
            case (state_q)
                IDLE:    src_ready = stray;
                XFER:    src_ready = grant_id ? {!pck_proc_full, 1'b0} : {1'b0, !pck_proc_full};
                default: src_ready = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_id     <= 1'b0;
            rr_prio      <= 1'b0;
            first_word   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (grant) begin
                grant_id   <= grant_src;
                rr_prio    <= ~grant_src;
                first_word <= 1'b1;
            end else if (accept) begin
                first_word <= 1'b0;
            end
            // Stray mid-packet words in IDLE and a second sop inside a packet are both violations.
            if (((state_q == IDLE) && (|stray)) || (accept && sel_sop && !first_word))
                protocol_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enq_req       <= 1'b0;
            in_sop        <= 1'b0;
            in_eop        <= 1'b0;
            pck_len_valid <= 1'b0;
            wr_data_i     <= '0;
            pck_len_i     <= '0;
        end else begin
            enq_req       <= accept;
            in_sop        <= accept && sel_sop;
            in_eop        <= accept && sel_eop;
            pck_len_valid <= accept && sel_sop;
            if (accept) begin
                wr_data_i <= sel_data;
                pck_len_i <= sel_len;
            end
        end
    end

`ifdef PKT_PROC_ENQ_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else if (accept && sel_eop) begin
            if (!grant_id && (pkt_cnt0 != 16'hFFFF)) pkt_cnt0 <= pkt_cnt0 + 16'd1;
            if (grant_id && (pkt_cnt1 != 16'hFFFF))  pkt_cnt1 <= pkt_cnt1 + 16'd1;
        end
    end
`else
    // Default build carries no per-source packet counters.
`endif

endmodule

// File: tb/tb_pkt_proc_enq_arb.sv
// Scoreboard bench for pkt_proc_enq_arb: source queues drive stimulus, a negedge monitor checks every enqueue.
module tb_pkt_proc_enq_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  src_valid, src_sop, src_eop;
    logic [63:0] src_data;
    logic [23:0] src_len;
    logic [1:0]  src_ready;
    logic        full = 1'b0;
    logic        afull = 1'b0;
    logic        enq_req, in_sop, in_eop, pck_len_valid;
    logic [31:0] wr_data_i;
    logic [11:0] pck_len_i;
    logic        grant_id, busy, protocol_err;
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
    logic [15:0] pkt_cnt0, pkt_cnt1;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [11:0] len;
    } word_t;

    typedef struct packed {
        word_t w;
        logic  gid;
    } exp_t;

    word_t src_q0[$];
    word_t src_q1[$];
    exp_t  exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int cyc = 0;
    int last_eop_cyc = -1;
    bit chk_bubble = 1'b0;
    logic [31:0] last_data = '0;
    logic [11:0] last_len = '0;

    always #5 clk = ~clk;

    pkt_proc_enq_arb dut (
        .pck_proc_int_mem_fsm_clk    (clk),
        .pck_proc_int_mem_fsm_sw_rst (rst),
        .src_valid                   (src_valid),
        .src_sop                     (src_sop),
        .src_eop                     (src_eop),
        .src_data                    (src_data),
        .src_len                     (src_len),
        .src_ready                   (src_ready),
        .pck_proc_full               (full),
        .pck_proc_almost_full        (afull),
        .enq_req                     (enq_req),
        .in_sop                      (in_sop),
        .in_eop                      (in_eop),
        .pck_len_valid               (pck_len_valid),
        .wr_data_i                   (wr_data_i),
        .pck_len_i                   (pck_len_i),
        .grant_id                    (grant_id),
        .busy                        (busy),
        .protocol_err                (protocol_err)
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
        ,
        .pkt_cnt0                    (pkt_cnt0),
        .pkt_cnt1                    (pkt_cnt1)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source driver: presents each queue's head word, pops it after a sampled handshake.
    initial begin : driver
        logic [1:0] fire;
        src_valid = '0; src_sop = '0; src_eop = '0; src_data = '0; src_len = '0;
        forever begin
            @(negedge clk);
            fire = src_valid & src_ready;
            @(posedge clk);
            #1;
            if (fire[0] && (src_q0.size() != 0)) void'(src_q0.pop_front());
            if (fire[1] && (src_q1.size() != 0)) void'(src_q1.pop_front());
            src_valid = {src_q1.size() != 0, src_q0.size() != 0};
            if (src_q0.size() != 0) begin
                src_data[31:0] = src_q0[0].data; src_sop[0] = src_q0[0].sop;
                src_eop[0] = src_q0[0].eop;      src_len[11:0] = src_q0[0].len;
            end else begin
                src_data[31:0] = '0; src_sop[0] = 1'b0; src_eop[0] = 1'b0; src_len[11:0] = '0;
            end
            if (src_q1.size() != 0) begin
                src_data[63:32] = src_q1[0].data; src_sop[1] = src_q1[0].sop;
                src_eop[1] = src_q1[0].eop;       src_len[23:12] = src_q1[0].len;
            end else begin
                src_data[63:32] = '0; src_sop[1] = 1'b0; src_eop[1] = 1'b0; src_len[23:12] = '0;
            end
        end
    end

    // Monitor: every enqueue must match the scoreboard head; idle cycles must hold data and clear controls.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            last_data    = '0;
            last_len     = '0;
            last_eop_cyc = -1;
        end else if (enq_req) begin
            if (exp_q.size() == 0) begin
                check("unexpected_enq", 64'(enq_req), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("out_data", 64'(wr_data_i), 64'(e.w.data));
                check("out_sop", 64'(in_sop), 64'(e.w.sop));
                check("out_eop", 64'(in_eop), 64'(e.w.eop));
                check("out_len_valid", 64'(pck_len_valid), 64'(e.w.sop));
                if (e.w.sop) check("out_len", 64'(pck_len_i), 64'(e.w.len));
                check("out_gid", 64'(grant_id), 64'(e.gid));
                if (chk_bubble && e.w.sop && (last_eop_cyc >= 0))
                    check("bubble_gap", 64'(cyc - last_eop_cyc), 64'(2));
                if (e.w.eop) last_eop_cyc = cyc;
            end
            n_out++;
            last_data = wr_data_i;
            last_len  = pck_len_i;
        end else begin
            check("idle_ctrl", 64'({in_sop, in_eop, pck_len_valid}), 64'(0));
            check("hold_data", 64'(wr_data_i), 64'(last_data));
            check("hold_len", 64'(pck_len_i), 64'(last_len));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        src_q0.delete();
        src_q1.delete();
        full = 1'b0;
        afull = 1'b0;
        chk_bubble = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic src, input logic [31:0] d, input logic s, input logic e,
                             input logic [11:0] len, input bit expect_out);
        word_t w;
        exp_t  x;
        w = '{data: d, sop: s, eop: e, len: len};
        x.w = w;
        x.gid = src;
        if (src) src_q1.push_back(w);
        else     src_q0.push_back(w);
        if (expect_out) exp_q.push_back(x);
    endtask

    task automatic push_pkt(input logic src, input logic [31:0] base, input int n, input logic [11:0] len);
        for (int k = 0; k < n; k++)
            push_word(src, base + 32'(k), k == 0, k == n - 1, len, 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (((exp_q.size() + src_q0.size() + src_q1.size()) != 0) && (k < 200)) begin
            @(posedge clk);
            k++;
        end
        check(name, 64'(exp_q.size() + src_q0.size() + src_q1.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n_out(input int target, input string name);
        int k = 0;
        while ((n_out < target) && (k < 100)) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(n_out >= target), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_ctrl"}, 64'({enq_req, in_sop, in_eop, pck_len_valid}), 64'(0));
        check({tag, "_data"}, 64'(wr_data_i), 64'(0));
        check({tag, "_len"}, 64'(pck_len_i), 64'(0));
        check({tag, "_gid"}, 64'(grant_id), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_perr"}, 64'(protocol_err), 64'(0));
        check({tag, "_ready"}, 64'(src_ready), 64'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int base;
        int k;

        do_reset();
        check_all_zero("rst");

        // Single 4-word packet from source 0.
        do_reset();
        base = n_out;
        push_pkt(1'b0, 32'h1, 4, 12'd16);
        wait_drain("pkt4_drain");
        check("pkt4_count", 64'(n_out - base), 64'(4));
        check("pkt4_perr", 64'(protocol_err), 64'(0));

        // Both sources contend with 2-word packets: grants 0,1,0,1 with one bubble each.
        do_reset();
        chk_bubble = 1'b1;
        push_pkt(1'b0, 32'hA0, 2, 12'd8);
        push_pkt(1'b1, 32'hB0, 2, 12'd9);
        push_pkt(1'b0, 32'hC0, 2, 12'd10);
        push_pkt(1'b1, 32'hD0, 2, 12'd11);
        wait_drain("rr_drain");
        chk_bubble = 1'b0;

        // Full stalls a packet for 3 cycles; almost-full afterwards must not stall it.
        do_reset();
        base = n_out;
        push_pkt(1'b0, 32'h100, 6, 12'd24);
        wait_n_out(base + 2, "stall_start");
        full = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("stall_ready", 64'(src_ready), 64'(0));
            if (j > 0) check("stall_enq", 64'(enq_req), 64'(0));
        end
        @(posedge clk);
        #1;
        full = 1'b0;
        afull = 1'b1;
        @(negedge clk);
        check("stall_enq_after", 64'(enq_req), 64'(0));
        check("afull_no_stall", 64'(src_ready), 64'(2'b01));
        wait_drain("stall_drain");
        afull = 1'b0;
        check("stall_count", 64'(n_out - base), 64'(6));

        // Almost-full blocks a new grant; release grants source 1.
        do_reset();
        afull = 1'b1;
        push_pkt(1'b1, 32'h200, 2, 12'd8);
        repeat (4) begin
            @(negedge clk);
            check("afull_idle_busy", 64'(busy), 64'(0));
            check("afull_idle_ready", 64'(src_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        afull = 1'b0;
        k = 0;
        while (!busy && (k < 10)) begin
            @(negedge clk);
            k++;
        end
        check("afull_release_busy", 64'(busy), 64'(1));
        check("afull_release_gid", 64'(grant_id), 64'(1));
        @(posedge clk);
        #1;
        wait_drain("afull_drain");

        // Stray word in IDLE is discarded and flags an error; reset mid-packet clears everything.
        do_reset();
        base = n_out;
        push_word(1'b0, 32'h55, 1'b0, 1'b0, 12'd0, 1'b0);
        k = 0;
        while (!protocol_err && (k < 10)) begin
            @(negedge clk);
            if (src_valid[0]) check("stray_ready", 64'(src_ready), 64'(2'b01));
            k++;
        end
        check("stray_perr", 64'(protocol_err), 64'(1));
        check("stray_discard", 64'(n_out), 64'(base));
        @(posedge clk);
        #1;
        push_pkt(1'b0, 32'h300, 5, 12'd20);
        wait_n_out(base + 2, "midrst_start");
        check("perr_sticky", 64'(protocol_err), 64'(1));
        do_reset();
        check_all_zero("mid_rst");

        // A second sop inside a packet is forwarded verbatim and flags an error.
        do_reset();
        push_word(1'b1, 32'h401, 1'b1, 1'b0, 12'd12, 1'b1);
        push_word(1'b1, 32'h402, 1'b1, 1'b0, 12'd13, 1'b1);
        push_word(1'b1, 32'h403, 1'b0, 1'b1, 12'd12, 1'b1);
        wait_drain("midsop_drain");
        check("midsop_perr", 64'(protocol_err), 64'(1));

        // Three single-word packets from source 1.
        do_reset();
        base = n_out;
        for (int p = 0; p < 3; p++) push_pkt(1'b1, 32'h500 + 32'(p), 1, 12'd4);
        wait_drain("single_drain");
        check("single_count", 64'(n_out - base), 64'(3));
        check("single_busy", 64'(busy), 64'(0));
        check("single_perr", 64'(protocol_err), 64'(0));
`ifdef PKT_PROC_ENQ_ARB_STATS_EN
        check("stats_cnt1", 64'(pkt_cnt1), 64'(3));
        check("stats_cnt0", 64'(pkt_cnt0), 64'(0));
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
